// File: rtl/display7seg_pkg.sv
// Shared code/segment constants and types for the multi-digit 7-segment controller.
package display7seg_pkg;

    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [SEG_W-1:0]  seg_t;

    // Extended character codes beyond the 0-F hex set
    localparam code_t CODE_G     = 5'h10;
    localparam code_t CODE_H     = 5'h11;
    localparam code_t CODE_I     = 5'h12;
    localparam code_t CODE_DASH  = 5'h13;
    localparam code_t CODE_BLANK = 5'h1F;
    localparam code_t CODE_ZERO  = 5'h00;

    // Active-low segment images, bit 6 = g (middle) .. bit 0 = a
    localparam seg_t SEG_OFF = 7'h7F;
    localparam seg_t SEG_ALL = 7'h00;

endpackage

// File: rtl/display7seg_if.sv
// Bundle between the debug datapath (master) and the display controller (slave).
interface display7seg_if #(
    parameter int N_DIGITS = 6
);
    // load is a single-cycle capture strobe with no back-pressure: codes are taken
    // on every rising edge where load=1; blink_en/lz_suppress/lamp_test are levels.
    logic                    load;
    logic [5*N_DIGITS-1:0]   codes;
    logic [N_DIGITS-1:0]     blink_en;
    logic                    lz_suppress;
    logic                    lamp_test;
    logic [7*N_DIGITS-1:0]   display;
    logic                    blink_phase;

    modport master (
        output load, codes, blink_en, lz_suppress, lamp_test,
        input  display, blink_phase
    );

    modport slave (
        input  load, codes, blink_en, lz_suppress, lamp_test,
        output display, blink_phase
    );
endinterface

// File: rtl/display7seg_seg7_decode.sv
// Combinational 5-bit character code to active-low 7-segment image.
module seg7_decode
    import display7seg_pkg::*;
(
    input  code_t i_code,
    output seg_t  o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_code)
            5'h00:     o_seg = 7'b1000000;
            5'h01:     o_seg = 7'b1111001;
            5'h02:     o_seg = 7'b0100100;
            5'h03:     o_seg = 7'b0110000;
            5'h04:     o_seg = 7'b0011001;
            5'h05:     o_seg = 7'b0010010;
            5'h06:     o_seg = 7'b0000010;
            5'h07:     o_seg = 7'b1111000;
            5'h08:     o_seg = 7'b0000000;
            5'h09:     o_seg = 7'b0010000;
            5'h0A:     o_seg = 7'b0001000;
            5'h0B:     o_seg = 7'b0000011;
            5'h0C:     o_seg = 7'b1000110;
            5'h0D:     o_seg = 7'b0100001;
            5'h0E:     o_seg = 7'b0000110;
            5'h0F:     o_seg = 7'b0001110;
            CODE_G:    o_seg = 7'b0000010;
            CODE_H:    o_seg = 7'b0001011;
            CODE_I:    o_seg = 7'b1111011;
            CODE_DASH: o_seg = 7'b0111111;
            default:   o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display7seg_ctrl.sv
// Registered multi-digit 7-segment controller: digit latches, blink timer,
// leading-zero suppression and lamp test feeding a registered output image.
module display7seg_ctrl
    import display7seg_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic          clock,
    input  logic          reset,
    display7seg_if.slave  io_bus
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    code_t                   r_digit [N_DIGITS];
    logic [CNT_W-1:0]        r_blink_cnt;
    logic                    r_blink_phase;
    logic [7*N_DIGITS-1:0]   r_display;

    seg_t                    w_seg [N_DIGITS];
    logic [N_DIGITS-1:0]     w_lz_blank;
    logic [7*N_DIGITS-1:0]   w_next_display;
    logic                    w_blink_wrap;

    generate
        for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
            seg7_decode u_dec (
                .i_code (r_digit[g]),
                .o_seg  (w_seg[g])
            );
        end
    endgenerate

    // Suppression runs from the leftmost digit and stops at the first non-zero code;
    // digit 0 is excluded so a value of zero still shows a single '0'.
    always_comb begin
        logic v_run;
        w_lz_blank = '0;
        v_run      = io_bus.lz_suppress;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            v_run         = v_run && (r_digit[i] == CODE_ZERO);
            w_lz_blank[i] = v_run;
        end
    end

    always_comb begin
        w_next_display = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (io_bus.lamp_test)
                w_next_display[7*i +: 7] = SEG_ALL;
            else if (r_blink_phase && io_bus.blink_en[i])
                w_next_display[7*i +: 7] = SEG_OFF;
            else if (w_lz_blank[i])
                w_next_display[7*i +: 7] = SEG_OFF;
            else
                w_next_display[7*i +: 7] = w_seg[i];
        end
    end

    assign w_blink_wrap = (r_blink_cnt == CNT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++)
                r_digit[i] <= CODE_BLANK;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_display     <= '1;
        end else begin
            if (io_bus.load) begin
                for (int i = 0; i < N_DIGITS; i++)
                    r_digit[i] <= io_bus.codes[5*i +: 5];
            end
            if (w_blink_wrap) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
            r_display <= w_next_display;
        end
    end

    assign io_bus.display     = r_display;
    assign io_bus.blink_phase = r_blink_phase;

endmodule
